// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the CPU datapath.
// Steps FETCH -> DECODE -> EXEC -> MEM -> WB. It drives the PC/IR load enables,
// the next-PC source, the RF/DM write strobes and the datapath mux selects.
// It also counts retired instructions. The PC reset value lives in the PC register.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,       // synchronous, active-low
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dm_ready,
  output logic             imem_req,
  output logic             dm_req,
  output logic             dm_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic [1:0]       rf_wa_sel,
  output logic [1:0]       rf_wd_sel,
  output logic [1:0]       alu_op,
  output logic             alu_b_sel,
  output logic             ext_op,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  // Opcode / funct encodings
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  // Datapath mux encodings
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_J     = 2'b10;
  localparam logic [1:0] PC_JR    = 2'b11;
  localparam logic [1:0] WA_RT    = 2'b00;
  localparam logic [1:0] WA_RD    = 2'b01;
  localparam logic [1:0] WA_RA    = 2'b10;
  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_DM    = 2'b01;
  localparam logic [1:0] WD_PC    = 2'b10;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_LUI  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instr_cnt_q;
  logic             boot_q;      // first cycle after reset: no PC/IR load yet
  logic             retire;

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_legal;

  // Instruction classification from the IR fields
  always_comb begin
    is_addu  = (opcode == OP_RTYPE) && (funct == FN_ADDU);
    is_subu  = (opcode == OP_RTYPE) && (funct == FN_SUBU);
    is_jr    = (opcode == OP_RTYPE) && (funct == FN_JR);
    is_ori   = (opcode == OP_ORI);
    is_lui   = (opcode == OP_LUI);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    is_j     = (opcode == OP_J);
    is_jal   = (opcode == OP_JAL);
    is_legal = is_addu | is_subu | is_jr | is_ori | is_lui |
               is_lw | is_sw | is_beq | is_j | is_jal;
  end

  // State, boot flag and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      instr_cnt_q <= '0;
      boot_q      <= 1'b1;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b0;
      if (retire) begin
        instr_cnt_q <= instr_cnt_q + CNT_ONE;
      end
    end
  end

  // Next-state and control-output decode
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    rf_we     = 1'b0;
    rf_wa_sel = WA_RT;
    rf_wd_sel = WD_ALU;
    alu_op    = ALU_ADD;
    alu_b_sel = 1'b0;
    ext_op    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        // The cycle after reset only requests; it never loads PC/IR.
        if (imem_ready && !boot_q) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_src  = PC_PLUS4;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_j) begin
          pc_we   = 1'b1;
          pc_src  = PC_J;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_jal) begin
          pc_we     = 1'b1;
          pc_src    = PC_J;
          rf_we     = 1'b1;
          rf_wa_sel = WA_RA;
          rf_wd_sel = WD_PC;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end else if (is_jr) begin
          pc_we   = 1'b1;
          pc_src  = PC_JR;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (!is_legal) begin
          // PC has already advanced past the bad word; drop it unretired.
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_addu || is_subu) begin
          alu_op  = is_subu ? ALU_SUB : ALU_ADD;
          state_d = S_WB;
        end else if (is_ori) begin
          alu_op    = ALU_OR;
          alu_b_sel = 1'b1;
          state_d   = S_WB;
        end else if (is_lui) begin
          alu_op    = ALU_LUI;
          alu_b_sel = 1'b1;
          state_d   = S_WB;
        end else if (is_lw || is_sw) begin
          alu_op    = ALU_ADD;
          alu_b_sel = 1'b1;
          ext_op    = 1'b1;
          state_d   = S_MEM;
        end else if (is_beq) begin
          alu_op  = ALU_SUB;
          ext_op  = 1'b1;
          if (zero) begin
            pc_we  = 1'b1;
            pc_src = PC_BR;
          end
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          // Opcode changed under us; recover without retiring.
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        dm_req = 1'b1;
        dm_we  = is_sw;
        if (dm_ready) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we = 1'b1;
        if (is_lw) begin
          rf_wa_sel = WA_RT;
          rf_wd_sel = WD_DM;
        end else if (opcode == OP_RTYPE) begin
          rf_wa_sel = WA_RD;
          rf_wd_sel = WD_ALU;
        end else begin
          rf_wa_sel = WA_RT;
          rf_wd_sel = WD_ALU;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench for mc_ctrl.
// For each instruction, a per-cycle list of expected control words is built
// from the instruction's phase rules. The bench compares that list cycle by cycle.
module tb_mc_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          zero;
  logic          imem_ready;
  logic          dm_ready;
  logic          imem_req;
  logic          dm_req;
  logic          dm_we;
  logic          ir_we;
  logic          pc_we;
  logic [1:0]    pc_src;
  logic          rf_we;
  logic [1:0]    rf_wa_sel;
  logic [1:0]    rf_wd_sel;
  logic [1:0]    alu_op;
  logic          alu_b_sel;
  logic          ext_op;
  logic          illegal;
  logic [CW-1:0] instr_cnt;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dm_ready(dm_ready), .imem_req(imem_req),
    .dm_req(dm_req), .dm_we(dm_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .rf_we(rf_we), .rf_wa_sel(rf_wa_sel),
    .rf_wd_sel(rf_wd_sel), .alu_op(alu_op), .alu_b_sel(alu_b_sel),
    .ext_op(ext_op), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  typedef struct packed {
    logic       imem_req;
    logic       dm_req;
    logic       dm_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       rf_we;
    logic [1:0] wa;
    logic [1:0] wd;
    logic [1:0] alu_op;
    logic       b_sel;
    logic       ext;
    logic       illegal;
  } ctl_t;

  ctl_t          exp_q[$];
  ctl_t          obs_q[$];
  bit            imr_q[$];
  bit            dmr_q[$];
  bit            fetch_q[$];
  logic [CW-1:0] cnt_obs_q[$];
  logic [CW-1:0] cnt_model;
  int            errors;
  int            checks;

  logic [5:0] op_tab[11] = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f};
  logic [5:0] fn_tab[11] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t observe();
    return {imem_req, dm_req, dm_we, ir_we, pc_we, pc_src, rf_we,
            rf_wa_sel, rf_wd_sel, alu_op, alu_b_sel, ext_op, illegal};
  endfunction

  task automatic push(input ctl_t c, input bit imr, input bit dmr, input bit fetch);
    exp_q.push_back(c);
    imr_q.push_back(imr);
    dmr_q.push_back(dmr);
    fetch_q.push_back(fetch);
  endtask

  // Expected per-cycle control words for one instruction, from the phase rules.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fwait, input int mwait, output bit ret);
    ctl_t c;
    bit rtype, addu, subu, jr, ori, lui, lw, sw, beq, j, jal, legal;
    rtype = (op == 6'h00);
    addu = rtype && fn == 6'h21;  subu = rtype && fn == 6'h23;  jr = rtype && fn == 6'h08;
    ori = op == 6'h0d;  lui = op == 6'h0f;  lw = op == 6'h23;  sw = op == 6'h2b;
    beq = op == 6'h04;  j = op == 6'h02;  jal = op == 6'h03;
    legal = addu | subu | jr | ori | lui | lw | sw | beq | j | jal;
    exp_q.delete(); imr_q.delete(); dmr_q.delete(); fetch_q.delete();
    ret = legal;
    for (int k = 0; k < fwait; k++) begin
      c = '0; c.imem_req = 1'b1;
      push(c, 1'b0, 1'($urandom), 1'b1);
    end
    c = '0; c.imem_req = 1'b1; c.ir_we = 1'b1; c.pc_we = 1'b1; c.pc_src = 2'b00;
    push(c, 1'b1, 1'($urandom), 1'b1);
    // DECODE
    c = '0;
    if (j)       begin c.pc_we = 1'b1; c.pc_src = 2'b10; end
    else if (jal) begin c.pc_we = 1'b1; c.pc_src = 2'b10; c.rf_we = 1'b1; c.wa = 2'b10; c.wd = 2'b10; end
    else if (jr)  begin c.pc_we = 1'b1; c.pc_src = 2'b11; end
    else if (!legal) c.illegal = 1'b1;
    push(c, 1'($urandom), 1'($urandom), 1'b0);
    if (j || jal || jr || !legal) return;
    // EXEC
    c = '0;
    if (subu) c.alu_op = 2'b01;
    if (ori) begin c.alu_op = 2'b10; c.b_sel = 1'b1; end
    if (lui) begin c.alu_op = 2'b11; c.b_sel = 1'b1; end
    if (lw || sw) begin c.b_sel = 1'b1; c.ext = 1'b1; end
    if (beq) begin c.alu_op = 2'b01; c.ext = 1'b1; c.pc_we = z; c.pc_src = z ? 2'b01 : 2'b00; end
    push(c, 1'($urandom), 1'($urandom), 1'b0);
    if (beq) return;
    // MEM
    if (lw || sw) begin
      c = '0; c.dm_req = 1'b1; c.dm_we = sw;
      for (int k = 0; k < mwait; k++) push(c, 1'($urandom), 1'b0, 1'b0);
      push(c, 1'($urandom), 1'b1, 1'b0);
      if (sw) return;
    end
    // WB
    c = '0; c.rf_we = 1'b1;
    c.wa = rtype ? 2'b01 : 2'b00;
    c.wd = lw ? 2'b01 : 2'b00;
    push(c, 1'($urandom), 1'($urandom), 1'b0);
  endtask

  // Drive one cycle per expected entry and capture what the DUT shows.
  task automatic run_trace(input logic [5:0] op, input logic [5:0] fn, input logic z);
    obs_q.delete(); cnt_obs_q.delete();
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (fetch_q[i]) begin
        opcode = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
      end else begin
        opcode = op; funct = fn; zero = z;
      end
      imem_ready = imr_q[i];
      dm_ready   = dmr_q[i];
      #1;
      obs_q.push_back(observe());
      cnt_obs_q.push_back(instr_cnt);
    end
  endtask

  task automatic test_reset();
    ctl_t c;
    @(negedge clk); reset = 1'b0; imem_ready = 1'b1; dm_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b1; imem_ready = 1'b1;
    #1;
    c = '0; c.imem_req = 1'b1;
    cnt_model = '0;
    checks++;
    if (observe() !== c) begin
      errors++; $display("FAIL reset_ctl got=%h exp=%h", observe(), c);
    end
    checks++;
    if (instr_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt got=%0d exp=0", instr_cnt);
    end
    $display("reset: ctl=%h cnt=%0d", observe(), instr_cnt);
  endtask

  task automatic test_alu();
    bit ret;
    for (int n = 0; n < 5; n++) begin
      build(op_tab[n], fn_tab[n], 1'($urandom), (n == 0) ? 0 : int'($urandom_range(0, 3)), 0, ret);
      run_trace(op_tab[n], fn_tab[n], 1'b0);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL alu op=%h fn=%h cyc=%0d got=%h exp=%h", op_tab[n], fn_tab[n], i, obs_q[i], exp_q[i]);
        end
        checks++;
        if (cnt_obs_q[i] !== cnt_model) begin
          errors++; $display("FAIL alu_cnt cyc=%0d got=%0d exp=%0d", i, cnt_obs_q[i], cnt_model);
        end
      end
      if (ret) cnt_model++;
      $display("alu: op=%h fn=%h cycles=%0d cnt=%0d", op_tab[n], fn_tab[n], exp_q.size(), cnt_model);
    end
  endtask

  task automatic test_mem();
    bit ret;
    logic [5:0] op;
    for (int n = 0; n < 4; n++) begin
      op = n[0] ? 6'h2b : 6'h23;
      build(op, 6'($urandom), 1'($urandom), 0, (n == 0) ? 3 : int'($urandom_range(0, 4)), ret);
      run_trace(op, 6'h00, 1'b0);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL mem op=%h cyc=%0d got=%h exp=%h", op, i, obs_q[i], exp_q[i]);
        end
      end
      if (ret) cnt_model++;
      @(negedge clk); imem_ready = 1'b0; #1;
      checks++;
      if (instr_cnt !== cnt_model) begin
        errors++; $display("FAIL mem_cnt got=%0d exp=%0d", instr_cnt, cnt_model);
      end
      $display("mem: op=%h cycles=%0d cnt=%0d", op, exp_q.size(), instr_cnt);
    end
  endtask

  task automatic test_beq();
    bit ret;
    for (int n = 0; n < 2; n++) begin
      build(6'h04, 6'($urandom), n[0] ? 1'b0 : 1'b1, 1, 0, ret);
      run_trace(6'h04, 6'h00, n[0] ? 1'b0 : 1'b1);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL beq zero=%0d cyc=%0d got=%h exp=%h", !n[0], i, obs_q[i], exp_q[i]);
        end
        checks++;
        if (cnt_obs_q[i] !== cnt_model) begin
          errors++; $display("FAIL beq_cnt got=%0d exp=%0d", cnt_obs_q[i], cnt_model);
        end
      end
      if (ret) cnt_model++;
      $display("beq: zero=%0d cnt=%0d", !n[0], cnt_model);
    end
  endtask

  task automatic test_jumps_illegal();
    bit ret;
    logic [5:0] ops[5] = '{6'h02, 6'h03, 6'h00, 6'h3f, 6'h00};
    logic [5:0] fns[5] = '{6'h00, 6'h00, 6'h08, 6'h00, 6'h20};
    for (int n = 0; n < 5; n++) begin
      build(ops[n], fns[n], 1'($urandom), 0, 0, ret);
      run_trace(ops[n], fns[n], 1'b0);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL jmp_ill op=%h fn=%h cyc=%0d got=%h exp=%h", ops[n], fns[n], i, obs_q[i], exp_q[i]);
        end
      end
      if (ret) cnt_model++;
      @(negedge clk); imem_ready = 1'b0; #1;
      checks++;
      if (instr_cnt !== cnt_model) begin
        errors++; $display("FAIL jmp_ill_cnt op=%h got=%0d exp=%0d", ops[n], instr_cnt, cnt_model);
      end
      $display("jump/illegal: op=%h fn=%h retired=%0d cnt=%0d", ops[n], fns[n], ret, instr_cnt);
    end
  endtask

  task automatic test_random();
    bit ret;
    int sel;
    logic [5:0] op, fn;
    logic z;
    for (int n = 0; n < 30; n++) begin
      sel = int'($urandom_range(0, 10));
      op = op_tab[sel]; fn = fn_tab[sel]; z = 1'($urandom);
      build(op, fn, z, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), ret);
      run_trace(op, fn, z);
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL random op=%h fn=%h z=%0d cyc=%0d got=%h exp=%h", op, fn, z, i, obs_q[i], exp_q[i]);
        end
        checks++;
        if (cnt_obs_q[i] !== cnt_model) begin
          errors++; $display("FAIL random_cnt cyc=%0d got=%0d exp=%0d", i, cnt_obs_q[i], cnt_model);
        end
      end
      if (ret) cnt_model++;
      $display("random: op=%h fn=%h z=%0d cycles=%0d cnt=%0d", op, fn, z, exp_q.size(), cnt_model);
    end
  endtask

  task automatic test_wrap();
    bit ret;
    while (cnt_model != {CW{1'b1}}) begin
      build(6'h02, 6'h00, 1'b0, 0, 0, ret);
      run_trace(6'h02, 6'h00, 1'b0);
      cnt_model++;
    end
    build(6'h02, 6'h00, 1'b0, 0, 0, ret);
    run_trace(6'h02, 6'h00, 1'b0);
    checks++;
    if (cnt_obs_q[0] !== {CW{1'b1}}) begin
      errors++; $display("FAIL wrap_pre got=%0d exp=%0d", cnt_obs_q[0], {CW{1'b1}});
    end
    cnt_model++;
    @(negedge clk); imem_ready = 1'b0; #1;
    checks++;
    if (instr_cnt !== cnt_model || instr_cnt !== '0) begin
      errors++; $display("FAIL wrap got=%0d exp=0", instr_cnt);
    end
    $display("wrap: cnt=%0d", instr_cnt);
  endtask

  task automatic test_reset_mid();
    bit ret;
    ctl_t c;
    build(6'h2b, 6'h00, 1'b0, 0, 10, ret);
    while (exp_q.size() > 5) begin
      void'(exp_q.pop_back()); void'(imr_q.pop_back());
      void'(dmr_q.pop_back()); void'(fetch_q.pop_back());
    end
    run_trace(6'h2b, 6'h00, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk); reset = 1'b0; dm_ready = 1'b1; imem_ready = 1'b1;
    @(negedge clk); reset = 1'b1; dm_ready = 1'b1; imem_ready = 1'b1;
    #1;
    cnt_model = '0;
    c = '0; c.imem_req = 1'b1;
    checks++;
    if (observe() !== c) begin
      errors++; $display("FAIL reset_mid_ctl got=%h exp=%h", observe(), c);
    end
    checks++;
    if (instr_cnt !== '0) begin
      errors++; $display("FAIL reset_mid_cnt got=%0d exp=0", instr_cnt);
    end
    $display("reset_mid: ctl=%h cnt=%0d", observe(), instr_cnt);
    build(6'h23, 6'h00, 1'b0, 0, 1, ret);
    run_trace(6'h23, 6'h00, 1'b0);
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    cnt_model++;
    $display("reset_mid: lw after reset cycles=%0d", exp_q.size());
  endtask

  initial begin
    errors = 0; checks = 0; cnt_model = '0;
    reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    imem_ready = 1'b0; dm_ready = 1'b0;
    test_reset();
    test_alu();
    test_mem();
    test_beq();
    test_jumps_illegal();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
